// File: rtl/slot_cfg_ctrl.sv
// Slot routing configuration controller: serial frame receiver plus break-before-make mode sequencer.
// Optional output watchdog enabled by defining SLOT_CFG_WDT_EN.
module slot_cfg_ctrl #(
  parameter int         NSLOTS       = 4,
  parameter int         SYNC_STAGES  = 2,
  parameter int         GUARD_CYCLES = 16,
  parameter logic [7:0] RESET_MODES  = 8'hA5
`ifdef SLOT_CFG_WDT_EN
  , parameter int       WDT_CYCLES   = 1048576
`endif
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  CFG_SCK,
  input  logic                  CFG_SDI,
  input  logic                  CFG_CS_N,
  output logic [2*NSLOTS-1:0]   SLOT_MODE,
  output logic [NSLOTS-1:0]     SLOT_OE,
  output logic                  CFG_BUSY,
  output logic                  CFG_ACK,
  output logic                  CFG_ERR
);

  typedef enum logic [1:0] {IDLE, CHECK, GUARD, APPLY} state_t;

  localparam int                  GW        = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [GW-1:0]       GUARD_LD  = GW'(GUARD_CYCLES - 1);
  localparam logic [2:0]          NSLOTS_L  = 3'(NSLOTS);
  localparam logic [2*NSLOTS-1:0] RST_MODES = RESET_MODES[2*NSLOTS-1:0];

  logic [SYNC_STAGES-1:0] sck_sync, sdi_sync, cs_sync;
  logic                   sck_d, cs_d;
  logic                   sck_s, sdi_s, cs_s;
  logic                   sck_rise, cs_fall, cs_rise;
  logic [15:0]            shreg;
  logic [4:0]             bit_cnt;
  logic [1:0]             f_slot, f_mode;
  logic                   frame_ok, frame_accept, frame_reject;
  state_t                 state;
  logic [GW-1:0]          guard_cnt;
  logic                   tgt_all;
  logic [1:0]             tgt_slot, tgt_mode, cur_mode;
  logic [2*NSLOTS-1:0]    mode_shift;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sck_sync <= '0;
      sdi_sync <= '0;
      cs_sync  <= '1;
      sck_d    <= 1'b0;
      cs_d     <= 1'b1;
    end else begin
      sck_sync[0] <= CFG_SCK;
      sdi_sync[0] <= CFG_SDI;
      cs_sync[0]  <= CFG_CS_N;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sck_sync[i] <= sck_sync[i-1];
        sdi_sync[i] <= sdi_sync[i-1];
        cs_sync[i]  <= cs_sync[i-1];
      end
      sck_d <= sck_s;
      cs_d  <= cs_s;
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign sdi_s    = sdi_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign cs_fall  = ~cs_s & cs_d;
  assign cs_rise  = cs_s & ~cs_d;

  // Receiver runs regardless of FSM state so frames arriving while busy are still seen and rejected.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (cs_fall) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (sck_rise && !cs_s) begin
      shreg <= {shreg[14:0], sdi_s};
      if (bit_cnt != 5'd17) bit_cnt <= bit_cnt + 5'd1;
    end
  end

  assign f_slot       = shreg[11:10];
  assign f_mode       = shreg[9:8];
  assign frame_ok     = (bit_cnt == 5'd16) && (shreg[15:12] == 4'hA) &&
                        (shreg[7:0] == ~shreg[15:8]) && (f_mode != 2'b11) &&
                        ({1'b0, f_slot} < NSLOTS_L);
  assign frame_accept = cs_rise && frame_ok && (state == IDLE);
  assign frame_reject = cs_rise && !frame_accept;

  assign mode_shift = SLOT_MODE >> {tgt_slot, 1'b0};
  assign cur_mode   = mode_shift[1:0];

`ifdef SLOT_CFG_WDT_EN
  localparam int WW = $clog2(WDT_CYCLES + 1);
  logic [WW-1:0] wdt_cnt;
  logic          wdt_trip;
  logic          any_out;

  always_comb begin
    any_out = 1'b0;
    for (int i = 0; i < NSLOTS; i++)
      if (SLOT_MODE[2*i +: 2] == 2'b10) any_out = 1'b1;
  end
`endif

  // Later assignments in this block take priority: rejects beat the APPLY error clear, and the watchdog beats routine OE updates.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= GUARD;
      guard_cnt <= GUARD_LD;
      tgt_all   <= 1'b1;
      tgt_slot  <= '0;
      tgt_mode  <= '0;
      SLOT_MODE <= RST_MODES;
      SLOT_OE   <= '0;
      CFG_BUSY  <= 1'b1;
      CFG_ACK   <= 1'b0;
      CFG_ERR   <= 1'b0;
`ifdef SLOT_CFG_WDT_EN
      wdt_cnt   <= '0;
      wdt_trip  <= 1'b0;
`endif
    end else begin
      CFG_ACK <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_accept) begin
            tgt_slot <= f_slot;
            tgt_mode <= f_mode;
            tgt_all  <= 1'b0;
            CFG_BUSY <= 1'b1;
            state    <= CHECK;
          end
        end
        CHECK: begin
          if (cur_mode == tgt_mode) begin
            state <= APPLY;
          end else begin
            SLOT_OE[tgt_slot] <= 1'b0;
            guard_cnt         <= GUARD_LD;
            state             <= GUARD;
          end
        end
        GUARD: begin
          if (guard_cnt == '0) state <= APPLY;
          else guard_cnt <= guard_cnt - 1'b1;
        end
        APPLY: begin
          CFG_ERR  <= 1'b0;
          CFG_ACK  <= 1'b1;
          CFG_BUSY <= 1'b0;
          state    <= IDLE;
          if (tgt_all) begin
            for (int i = 0; i < NSLOTS; i++)
              SLOT_OE[i] <= (SLOT_MODE[2*i +: 2] != 2'b00);
            tgt_all <= 1'b0;
          end else begin
`ifdef SLOT_CFG_WDT_EN
            if (wdt_trip) begin
              for (int i = 0; i < NSLOTS; i++)
                SLOT_OE[i] <= (SLOT_MODE[2*i +: 2] != 2'b00);
              wdt_trip <= 1'b0;
            end
`endif
            SLOT_MODE[{tgt_slot, 1'b0} +: 2] <= tgt_mode;
            SLOT_OE[tgt_slot]                <= (tgt_mode != 2'b00);
          end
        end
        default: state <= IDLE;
      endcase

      if (frame_reject) CFG_ERR <= 1'b1;

`ifdef SLOT_CFG_WDT_EN
      if (frame_accept) begin
        wdt_cnt <= '0;
      end else if (any_out && !wdt_trip) begin
        if (wdt_cnt == WW'(WDT_CYCLES - 1)) begin
          wdt_trip <= 1'b1;
          CFG_ERR  <= 1'b1;
          for (int i = 0; i < NSLOTS; i++)
            if (SLOT_MODE[2*i +: 2] == 2'b10) SLOT_OE[i] <= 1'b0;
        end else begin
          wdt_cnt <= wdt_cnt + 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_slot_cfg_ctrl.sv
// Directed, table-driven bench for slot_cfg_ctrl (default build, SLOT_CFG_WDT_EN undefined).
// A second instance with a long guard window exercises a frame arriving while busy.
module tb_slot_cfg_ctrl;

  localparam int GUARD      = 16;
  localparam int SLOW_GUARD = 64;

  logic       CLK = 1'b0;
  logic       RESET_N, slow_rst_n;
  logic       CFG_SCK, CFG_SDI, CFG_CS_N;
  logic [7:0] SLOT_MODE, slow_mode;
  logic [3:0] SLOT_OE, slow_oe;
  logic       CFG_BUSY, CFG_ACK, CFG_ERR;
  logic       slow_busy, slow_ack, slow_err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] frame;
    int          nbits;
    bit          accept;
    logic [7:0]  exp_mode;
    logic [3:0]  exp_oe;
    int          exp_lat;
    int          exp_low;
    bit          exp_err;
  } vec_t;

  vec_t vecs[14];

  always #5 CLK = ~CLK;

  slot_cfg_ctrl #(.NSLOTS(4), .SYNC_STAGES(2), .GUARD_CYCLES(GUARD), .RESET_MODES(8'hA5)) u_dut (
    .CLK(CLK), .RESET_N(RESET_N), .CFG_SCK(CFG_SCK), .CFG_SDI(CFG_SDI), .CFG_CS_N(CFG_CS_N),
    .SLOT_MODE(SLOT_MODE), .SLOT_OE(SLOT_OE), .CFG_BUSY(CFG_BUSY), .CFG_ACK(CFG_ACK), .CFG_ERR(CFG_ERR)
  );

  slot_cfg_ctrl #(.NSLOTS(4), .SYNC_STAGES(2), .GUARD_CYCLES(SLOW_GUARD), .RESET_MODES(8'hA5)) u_slow (
    .CLK(CLK), .RESET_N(slow_rst_n), .CFG_SCK(CFG_SCK), .CFG_SDI(CFG_SDI), .CFG_CS_N(CFG_CS_N),
    .SLOT_MODE(slow_mode), .SLOT_OE(slow_oe), .CFG_BUSY(slow_busy), .CFG_ACK(slow_ack), .CFG_ERR(slow_err)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Frame is driven MSB first, one bit per two clocks; bits beyond 16 are zeros.
  task automatic applyStimulus(input logic [15:0] frame, input int nbits);
    CFG_CS_N = 1'b0;
    repeat (3) @(negedge CLK);
    for (int i = 0; i < nbits; i++) begin
      CFG_SDI = (i < 16) ? frame[15-i] : 1'b0;
      @(negedge CLK);
      CFG_SCK = 1'b1;
      @(negedge CLK);
      CFG_SCK = 1'b0;
    end
    CFG_SDI = 1'b0;
    repeat (2) @(negedge CLK);
    CFG_CS_N = 1'b1;
  endtask

  // Called with reset already asserted; checks reset values, releases, and times the power-up guard.
  task automatic post_reset_check(input string tag);
    int  ack_at;
    bit  oe_low_ok;
    checkOutput({tag, "_rst_mode"}, SLOT_MODE, 8'hA5);
    checkOutput({tag, "_rst_oe"},   SLOT_OE,   4'h0);
    checkOutput({tag, "_rst_busy"}, CFG_BUSY,  1'b1);
    checkOutput({tag, "_rst_ack"},  CFG_ACK,   1'b0);
    checkOutput({tag, "_rst_err"},  CFG_ERR,   1'b0);
    repeat (2) @(negedge CLK);
    RESET_N   = 1'b1;
    ack_at    = 0;
    oe_low_ok = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge CLK);
      if (CFG_ACK) begin
        ack_at = c;
        break;
      end
      if (SLOT_OE != 4'h0) oe_low_ok = 1'b0;
    end
    checkOutput({tag, "_ack_cycle"}, ack_at, GUARD + 1);
    checkOutput({tag, "_oe_held_low"}, oe_low_ok, 1'b1);
    checkOutput({tag, "_oe_up"},   SLOT_OE,   4'hF);
    checkOutput({tag, "_mode"},    SLOT_MODE, 8'hA5);
    checkOutput({tag, "_idle"},    CFG_BUSY,  1'b0);
    @(negedge CLK);
    checkOutput({tag, "_ack_once"}, CFG_ACK, 1'b0);
  endtask

  task automatic expect_accepted(input vec_t tv, input string name, input logic [3:0] prev_oe);
    logic [1:0] slot;
    logic [3:0] mask;
    int         lat, low;
    bit         got, others_ok;
    slot      = tv.frame[11:10];
    mask      = ~(4'b0001 << slot);
    got       = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (CFG_BUSY) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput({name, "_busy"}, got, 1'b1);
    lat       = 0;
    low       = 0;
    others_ok = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge CLK);
      if (CFG_ACK) begin
        lat = c;
        break;
      end
      if (!SLOT_OE[slot]) low++;
      if ((SLOT_OE & mask) != (prev_oe & mask)) others_ok = 1'b0;
    end
    checkOutput({name, "_ack_lat"},   lat,       tv.exp_lat);
    checkOutput({name, "_oe_low"},    low,       tv.exp_low);
    checkOutput({name, "_others"},    others_ok, 1'b1);
    checkOutput({name, "_mode"},      SLOT_MODE, tv.exp_mode);
    checkOutput({name, "_oe"},        SLOT_OE,   tv.exp_oe);
    checkOutput({name, "_busy_done"}, CFG_BUSY,  1'b0);
    checkOutput({name, "_err"},       CFG_ERR,   tv.exp_err);
    @(negedge CLK);
    checkOutput({name, "_ack_once"}, CFG_ACK, 1'b0);
  endtask

  task automatic expect_rejected(input vec_t tv, input string name);
    bit activity;
    activity = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      if (CFG_BUSY || CFG_ACK) activity = 1'b1;
    end
    checkOutput({name, "_no_busy"}, activity,  1'b0);
    checkOutput({name, "_err"},     CFG_ERR,   tv.exp_err);
    checkOutput({name, "_mode"},    SLOT_MODE, tv.exp_mode);
    checkOutput({name, "_oe"},      SLOT_OE,   tv.exp_oe);
  endtask

  initial begin
    logic [3:0] prev_oe;
    bit         seen;

    // Changed mode: ack 18 samples after CHECK (16 guard + apply + idle), OE low on 17 of them.
    vecs[0]  = '{16'hA857, 16, 1'b1, 8'h85, 4'hB, 18, 17, 1'b0};
    vecs[1]  = '{16'hA55A, 16, 1'b1, 8'h85, 4'hB,  2,  0, 1'b0};
    vecs[2]  = '{16'hA55A, 15, 1'b0, 8'h85, 4'hB,  0,  0, 1'b1};
    vecs[3]  = '{16'hA55A, 16, 1'b1, 8'h85, 4'hB,  2,  0, 1'b0};
    vecs[4]  = '{16'hA758, 16, 1'b0, 8'h85, 4'hB,  0,  0, 1'b1};
    vecs[5]  = '{16'hA55A, 16, 1'b1, 8'h85, 4'hB,  2,  0, 1'b0};
    vecs[6]  = '{16'hA800, 16, 1'b0, 8'h85, 4'hB,  0,  0, 1'b1};
    vecs[7]  = '{16'hA55A, 16, 1'b1, 8'h85, 4'hB,  2,  0, 1'b0};
    vecs[8]  = '{16'hA55A, 17, 1'b0, 8'h85, 4'hB,  0,  0, 1'b1};
    vecs[9]  = '{16'hA55A, 16, 1'b1, 8'h85, 4'hB,  2,  0, 1'b0};
    vecs[10] = '{16'h0000,  0, 1'b0, 8'h85, 4'hB,  0,  0, 1'b1};
    vecs[11] = '{16'hAA55, 16, 1'b1, 8'hA5, 4'hF, 18, 17, 1'b0};
    vecs[12] = '{16'hA05F, 16, 1'b1, 8'hA4, 4'hE, 18, 17, 1'b0};
    vecs[13] = '{16'hA15E, 16, 1'b1, 8'hA5, 4'hF, 18, 17, 1'b0};

    RESET_N    = 1'b0;
    slow_rst_n = 1'b0;
    CFG_SCK    = 1'b0;
    CFG_SDI    = 1'b0;
    CFG_CS_N   = 1'b1;
    repeat (3) @(negedge CLK);
    post_reset_check("por");

    for (int v = 0; v < 14; v++) begin
      prev_oe = SLOT_OE;
      applyStimulus(vecs[v].frame, vecs[v].nbits);
      if (vecs[v].accept) expect_accepted(vecs[v], $sformatf("v%0d", v), prev_oe);
      else                expect_rejected(vecs[v], $sformatf("v%0d", v));
      repeat (3) @(negedge CLK);
    end

    // Frame landing inside a long guard window: rejected, in-flight change still completes.
    slow_rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      if (slow_ack) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("slow_ready", seen, 1'b1);
    repeat (2) @(negedge CLK);
    applyStimulus(16'hAD52, 16);
    repeat (2) @(negedge CLK);
    applyStimulus(16'hA55A, 16);
    repeat (4) @(negedge CLK);
    checkOutput("busy_rej_err",  slow_err,  1'b1);
    checkOutput("busy_rej_busy", slow_busy, 1'b1);
    checkOutput("busy_rej_mode", slow_mode, 8'hA5);
    checkOutput("busy_rej_oe",   slow_oe,   4'h7);
    seen = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(negedge CLK);
      if (slow_ack) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("busy_inflight_ack",  seen,      1'b1);
    checkOutput("busy_inflight_mode", slow_mode, 8'h65);
    checkOutput("busy_inflight_oe",   slow_oe,   4'hF);
    checkOutput("idle_same_frame_err",  CFG_ERR,   1'b0);
    checkOutput("idle_same_frame_mode", SLOT_MODE, 8'h65);
    checkOutput("idle_same_frame_oe",   SLOT_OE,   4'hF);

    // Reset five cycles into a guard window.
    repeat (3) @(negedge CLK);
    applyStimulus(16'hA857, 16);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (CFG_BUSY) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("midguard_busy", seen, 1'b1);
    repeat (5) @(negedge CLK);
    checkOutput("midguard_oe2_low", SLOT_OE[2], 1'b0);
    RESET_N = 1'b0;
    #1;
    post_reset_check("midguard");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
